// File: rtl/mult_bcd_conv.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter for the multiplier product.
// Optional macro MULT_BCD_SEG7_EN adds an active-low seven-segment decode of bcd_out.
module mult_bcd_conv #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef MULT_BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg_out
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   adjusted;

  // Each digit that would reach 10 or more after the coming doubling is pre-corrected by +3.
  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] s);
    logic [4*DIGITS-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adjusted = add3(scratch_q);

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default for every comb-assigned signal up front prevents inferred latches.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (count_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values, steered by the current state.
  always_comb begin
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    count_d   = count_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scratch_d = '0;
          count_d   = CW'(WIDTH);
        end
      end
      S_SHIFT: begin
        scratch_d = {adjusted[4*DIGITS-2:0], bin_q[WIDTH-1]};
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        count_d   = count_q - CW'(1);
      end
      S_DONE: begin
        bcd_d  = scratch_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs; a start arriving in the done cycle is accepted because busy has already dropped.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = done_q;
    bcd_out = bcd_q;
  end

`ifdef MULT_BCD_SEG7_EN
  // Active-low {g,f,e,d,c,b,a}; codes 10..15 blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  always_comb begin
    seg_out = '1;
    for (int k = 0; k < DIGITS; k++) begin
      seg_out[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
    end
  end
`endif

endmodule

// File: tb/tb_mult_bcd_conv.sv
// Self-checking bench for mult_bcd_conv: scoreboard of expected BCD results checked on every done pulse.
module tb_mult_bcd_conv;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int LAT    = WIDTH + 1;

  logic                clk;
  logic                rst;
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
`ifdef MULT_BCD_SEG7_EN
  logic [7*DIGITS-1:0] seg_out;
`endif

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [4*DIGITS-1:0] exp_q[$];

  mult_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
`ifdef MULT_BCD_SEG7_EN
    ,
    .seg_out (seg_out)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      logic [11:0] exp;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: bcd_out=%h, required no done pulse", bcd_out);
      end else begin
        exp = exp_q.pop_front();
        if (bcd_out !== exp) begin
          errors++;
          $display("FAIL scoreboard_bcd: bcd_out=%h, required %h", bcd_out, exp);
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns edges from acceptance until done is seen.
  task automatic convert(input logic [WIDTH-1:0] v, output int lat);
    start  = 1'b1;
    bin_in = v;
    exp_q.push_back(to_bcd(int'(v)));
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = WIDTH'($urandom);
    lat    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bin_in = '0;
    idle(2);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd_out);
    end
`ifdef MULT_BCD_SEG7_EN
    checks++;
    if (seg_out !== {3{7'b1000000}}) begin
      errors++;
      $display("FAIL reset_seg: seg_out=%b, required %b", seg_out, {3{7'b1000000}});
    end
`endif
  endtask

  task automatic test_zero;
    int lat;
    int base;
    base = done_cnt;
    convert(8'd0, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL zero_latency: edges=%0d, required %0d", lat, LAT);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || done_cnt != base + 1) begin
      errors++;
      $display("FAIL zero_single_pulse: done=%b pulses=%0d, required 0 and %0d", done, done_cnt - base, 1);
    end
  endtask

  task automatic test_values;
    logic [WIDTH-1:0] vals[4] = '{8'd225, 8'd6, 8'd54, 8'd255};
    int lat;
    foreach (vals[i]) begin
      convert(vals[i], lat);
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL value_latency: value=%0d edges=%0d, required %0d", vals[i], lat, LAT);
      end
`ifdef MULT_BCD_SEG7_EN
      if (vals[i] == 8'd225) begin
        checks++;
        if (seg_out !== 21'b0100100_0100100_0010010) begin
          errors++;
          $display("FAIL seg_225: seg_out=%b, required %b", seg_out, 21'b0100100_0100100_0010010);
        end
      end
`endif
      idle(2);
    end
  endtask

  task automatic test_ignore_busy;
    int lat;
    int base;
    base   = done_cnt;
    start  = 1'b1;
    bin_in = 8'd15;
    exp_q.push_back(to_bcd(15));
    @(posedge clk); #1;
    bin_in = 8'd50;
    lat    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat   = n;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL busy_latency: edges=%0d, required %0d", lat, LAT);
    end
    idle(12);
    checks++;
    if (done_cnt != base + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignored: pulses=%0d busy=%b, required 1 and 0", done_cnt - base, busy);
    end
    convert(8'd50, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL after_busy_latency: edges=%0d, required %0d", lat, LAT);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    int base;
    base   = done_cnt;
    start  = 1'b1;
    bin_in = 8'd54;
    @(posedge clk); #1;
    start = 1'b0;
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_state: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd_out);
    end
    rst = 1'b0;
    idle(15);
    checks++;
    if (done_cnt != base || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_done: pulses=%0d busy=%b, required 0 and 0", done_cnt - base, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    convert(8'd10, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL b2b_first_latency: edges=%0d, required %0d", lat, LAT);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_in_done: busy=%b, required 0", busy);
    end
    convert(8'd15, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL b2b_second_latency: edges=%0d, required %0d", lat, LAT);
    end
    idle(2);
  endtask

  task automatic test_hold_during;
    start  = 1'b1;
    bin_in = 8'd99;
    exp_q.push_back(to_bcd(99));
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 8'd1;
    idle(4);
    checks++;
    if (busy !== 1'b1 || bcd_out !== 12'h015) begin
      errors++;
      $display("FAIL hold_old_value: busy=%b bcd=%h, required 1 015", busy, bcd_out);
    end
    idle(8);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin_in = '0;
    test_reset();
    test_zero();
    test_values();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_hold_during();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: outstanding=%0d, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
